// File: rtl/clb_config_loader_if.sv
// clb_config_loader_if: start/serial-stream/CLB-write bundle between a config source and the loader
interface clb_config_loader_if #(parameter int NUM_CLB = 4, parameter int CFG_W = 23);
  logic start_i;
  logic ser_data_i;
  logic ser_valid_i;
  logic ser_ready_o;
  logic [NUM_CLB-1:0] wr_en_o;
  logic [CFG_W-1:0] bits_o;
  logic busy_o;
  logic done_o;
  logic err_o;
  modport master(output start_i, ser_data_i, ser_valid_i, input ser_ready_o, wr_en_o, bits_o, busy_o, done_o, err_o);
  modport slave(input start_i, ser_data_i, ser_valid_i, output ser_ready_o, wr_en_o, bits_o, busy_o, done_o, err_o);
endinterface

// File: rtl/clb_config_loader.sv
// clb_config_loader: serial-to-CFG_W deserializer writing NUM_CLB CLBs in order; define CFG_PARITY_EN for even parity per frame
module clb_config_loader #(
  parameter int NUM_CLB = 4,
  parameter int CFG_W = 23
) (
  input logic clk_i,
  input logic rst_i,
  clb_config_loader_if.slave bus
);
`ifdef CFG_PARITY_EN
  localparam int FRAME_W = CFG_W + 1;
`else
  localparam int FRAME_W = CFG_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int IDX_W = NUM_CLB > 1 ? $clog2(NUM_CLB) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
  state_t state_q, state_d;
  logic [FRAME_W-2:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CFG_W-1:0] bits_q, bits_d;
  logic done_q, done_d, err_q, err_d;
  logic [FRAME_W-1:0] frame;
  logic last;
  // the incoming bit completes the frame combinationally, so bits_o loads on the accepting edge
  assign frame = {sr_q, bus.ser_data_i};
  assign last = bus.ser_valid_i && cnt_q == CNT_W'(FRAME_W - 1);
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    bits_d = bits_q;
    done_d = done_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        cnt_d = '0;
        idx_d = '0;
        done_d = 1'b0;
        err_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: if (bus.ser_valid_i) begin
        sr_d = frame[FRAME_W-2:0];
        cnt_d = cnt_q + 1'b1;
`ifdef CFG_PARITY_EN
        if (last && ^frame) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          bits_d = frame[FRAME_W-1:1];
          state_d = WRITE;
        end
`else
        if (last) begin
          bits_d = frame;
          state_d = WRITE;
        end
`endif
      end
      WRITE: if (idx_q == IDX_W'(NUM_CLB - 1)) begin
        done_d = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
        cnt_d = '0;
        state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      bits_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      bits_q <= bits_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign bus.ser_ready_o = state_q == SHIFT;
  assign bus.busy_o = state_q != IDLE;
  assign bus.wr_en_o = state_q == WRITE ? NUM_CLB'(1) << idx_q : '0;
  assign bus.bits_o = bits_q;
  assign bus.done_o = done_q;
  assign bus.err_o = err_q;
endmodule

// File: tb/tb_clb_config_loader.sv
// tb_clb_config_loader: directed table-driven bench for clb_config_loader
module tb_clb_config_loader;
  localparam int N = 4;
  localparam int W = 23;
`ifdef CFG_PARITY_EN
  localparam int FW = W + 1;
`else
  localparam int FW = W;
`endif
  typedef struct {
    logic [W-1:0] word;
    logic [N-1:0] wr;
  } vec_t;
  typedef struct {
    logic [N-1:0] wr;
    logic [W-1:0] bits;
    int cyc;
    logic done;
    logic busy;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int multi = 0;
  bit hold = 1'b0;
  vec_t vecs[N];
  ev_t log_q[$];
  clb_config_loader_if #(.NUM_CLB(N), .CFG_W(W)) bus();
  clb_config_loader #(.NUM_CLB(N), .CFG_W(W)) dut(.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.wr_en_o != '0) begin
    log_q.push_back('{bus.wr_en_o, bus.bits_o, cyc, bus.done_o, bus.busy_o});
    if ($countones(bus.wr_en_o) != 1) multi++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  function automatic logic [FW-1:0] mk(input logic [W-1:0] w);
`ifdef CFG_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction
  task automatic send_bit(input logic b, input bit gaps);
    int budget = 0;
    bit acc;
    do begin
      @(negedge clk);
      if (!hold) bus.start_i = 1'b0;
      bus.ser_valid_i = !gaps || ($urandom_range(0, 1) == 1);
      bus.ser_data_i = b;
      acc = bus.ser_valid_i && bus.ser_ready_o;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d required=<200", budget);
    end
  endtask
  task automatic send_frame(input logic [FW-1:0] f, input bit gaps, input int nbits);
    for (int i = FW - 1; i >= FW - nbits; i--) send_bit(f[i], gaps);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_wr"}, 32'(bus.wr_en_o), 0);
    chk({tag, "_bits"}, 32'(bus.bits_o), 0);
    chk({tag, "_done"}, 32'(bus.done_o), 0);
    chk({tag, "_err"}, 32'(bus.err_o), 0);
    chk({tag, "_ready"}, 32'(bus.ser_ready_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
  endtask
  task automatic run_session(input bit gaps, input bit hld, input string tag);
    int t0;
    log_q.delete();
    hold = hld;
    @(negedge clk);
    bus.start_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < N; i++) send_frame(mk(vecs[i].word), gaps, FW);
    @(negedge clk);
    bus.ser_valid_i = 1'b0;
    chk({tag, "_strobe_done"}, 32'(bus.done_o), 0);
    chk({tag, "_strobe_busy"}, 32'(bus.busy_o), 1);
    @(negedge clk);
    bus.start_i = 1'b0;
    hold = 1'b0;
    chk({tag, "_done"}, 32'(bus.done_o), 1);
    chk({tag, "_busy_end"}, 32'(bus.busy_o), 0);
    chk({tag, "_wr_end"}, 32'(bus.wr_en_o), 0);
    chk({tag, "_bits_hold"}, 32'(bus.bits_o), 32'(vecs[N-1].word));
    chk({tag, "_count"}, log_q.size(), N);
    for (int i = 0; i < N && i < log_q.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), 32'(log_q[i].wr), 32'(vecs[i].wr));
      chk($sformatf("%s_bits%0d", tag, i), 32'(log_q[i].bits), 32'(vecs[i].word));
      chk($sformatf("%s_busy%0d", tag, i), 32'(log_q[i].busy), 1);
      if (!gaps) chk($sformatf("%s_cyc%0d", tag, i), log_q[i].cyc - t0, (i + 1) * (FW + 1));
    end
  endtask
  initial begin
    vecs[0] = '{23'h035237, 4'b0001};
    vecs[1] = '{23'h365A37, 4'b0010};
    vecs[2] = '{23'h78FF00, 4'b0100};
    vecs[3] = '{23'h000001, 4'b1000};
    bus.start_i = 1'b0;
    bus.ser_data_i = 1'b0;
    bus.ser_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy_o), 0);
    run_session(1'b0, 1'b0, "cont");
    run_session(1'b1, 1'b0, "gaps");
    run_session(1'b0, 1'b1, "hold");
    repeat (2) @(negedge clk);
    chk("hold_no_restart", 32'(bus.busy_o), 0);
    log_q.delete();
    @(negedge clk);
    bus.start_i = 1'b1;
    send_frame(mk(vecs[0].word), 1'b0, FW);
    send_frame(mk(vecs[1].word), 1'b0, 10);
    @(negedge clk);
    rst = 1'b1;
    bus.ser_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrst");
    chk("midrst_strobes", log_q.size(), 1);
    run_session(1'b0, 1'b0, "after_rst");
`ifdef CFG_PARITY_EN
    log_q.delete();
    @(negedge clk);
    bus.start_i = 1'b1;
    send_frame(mk(vecs[0].word), 1'b0, FW);
    send_frame(mk(vecs[1].word) ^ FW'(1), 1'b0, FW);
    @(negedge clk);
    bus.ser_valid_i = 1'b0;
    chk("par_wr", 32'(bus.wr_en_o), 0);
    chk("par_err", 32'(bus.err_o), 1);
    chk("par_done", 32'(bus.done_o), 0);
    chk("par_busy", 32'(bus.busy_o), 0);
    chk("par_bits", 32'(bus.bits_o), 32'(vecs[0].word));
    chk("par_strobes", log_q.size(), 1);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("par_err_clr", 32'(bus.err_o), 0);
    chk("par_restart", 32'(bus.busy_o), 1);
`endif
    chk("onehot", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
